siso_shift_register: RTL and testbench
======================================

Name: siso_shift_register

Overview:
- Serial-in/serial-out delay line: one bit per rising clk edge enters at data_in and leaves at data_out DEPTH edges later.
- Used as a fixed bit-delay / alignment element on single-bit serial paths.
- Adds a fill tracker so downstream logic knows when data_out carries real shifted data rather than reset fill.

Parameters:
- DEPTH, 4, number of register stages (>=1); latency in clk cycles from data_in to data_out.
- RESET_VAL, 1'b0, value loaded into every stage on reset.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  reset, asynchronous, active-low; assertion takes effect immediately, deassertion is sampled on clk.
- data_in  input  1  serial bit, sampled every rising clk edge while rst is high.
- data_out  output  1  serial bit, equal to the last stage (stage[DEPTH-1]).
- out_valid  output  1  high once DEPTH shifts have occurred since the last reset.
- fill_cnt  output  $clog2(DEPTH+1)  number of shifts since reset, saturating at DEPTH.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Storage is stage[0..DEPTH-1]. On every rising clk edge with rst=1:
  - stage[0] <= data_in;
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1.
- Shifting is unconditional: there is no enable and no handshake.
- data_out = stage[DEPTH-1], registered with no combinational path from data_in.
- Latency: a bit sampled at edge N appears on data_out after edge N+DEPTH-1, i.e. it is visible during cycle N+DEPTH-1 to N+DEPTH.
- While rst=0, asynchronously:
  - all stages = RESET_VAL;
  - data_out = RESET_VAL;
  - fill_cnt = 0;
  - out_valid = 0.
- fill_cnt increments by 1 on each edge with rst=1 and saturates at DEPTH; it never wraps.
- out_valid = (fill_cnt == DEPTH), registered alongside fill_cnt. It stays high until the next reset.
- DEPTH=1 degenerates to a single D flip-flop; out_valid rises after the first edge.
- Reset asserted mid-stream discards all in-flight bits immediately. After release, refill takes DEPTH edges again.
- X on data_in propagates through the stages; there is no filtering.

Optional Feature:
- Macro SISO_PARALLEL_TAP_EN.
- Defined: adds output port tap_out [DEPTH-1:0], a direct registered view of stage[DEPTH-1:0] (bit 0 = newest sample). It resets to {DEPTH{RESET_VAL}}. Serial behaviour is unchanged.
- Undefined: the port does not exist and no extra logic is generated.

Decomposition:
- Shared package siso_pkg holds:
  - SISO_DEFAULT_DEPTH = 4;
  - SISO_RESET_VAL = 1'b0;
  - a function computing the fill_cnt width (clog2(DEPTH+1)).
- One natural sub-module, siso_stage: a single async-active-low-reset D flop with a RESET_VAL parameter. It is instantiated DEPTH times in a generate loop.
- The fill counter stays in the top module.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles with data_in=1 -> data_out=0, fill_cnt=0, out_valid=0 throughout.
- Single pulse latency (DEPTH=4): release rst, drive data_in=1 for one edge then 0 -> data_out=1 for exactly one cycle after the 4th edge, 0 otherwise.
- Pattern 1,0,1,1 shifted in (DEPTH=4):
  - after edges 4..7, data_out shows 1,0,1,1 in order;
  - fill_cnt reads 1,2,3,4 after edges 1..4, then stays 4;
  - out_valid rises after edge 4.
- Async reset mid-stream: after 2 shifts of 1, pull rst low between edges -> data_out, fill_cnt and out_valid clear immediately without a clock edge; refill needs 4 more edges.
- DEPTH=1 build: data_in toggling 1,0,1 -> data_out follows one cycle later; out_valid=1 after the first edge.
- SISO_PARALLEL_TAP_EN build, DEPTH=4, shift in 1,1,0,1 -> tap_out=4'b1011 (bit0 newest); undefined build elaborates without tap_out.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared constants and helpers for the serial-in/serial-out delay line.
package siso_pkg;

    localparam int   SISO_DEFAULT_DEPTH = 4;
    localparam logic SISO_RESET_VAL     = 1'b0;

    // fill_cnt must be able to hold the value DEPTH itself
    function automatic int siso_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/siso_stage.sv
// One delay-line stage: a D flop with asynchronous active-low reset.
module siso_stage #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= RESET_VAL;
        else        r_q <= d;
    end

    assign q = r_q;

endmodule

// File: rtl/siso_shift_register.sv
// DEPTH-stage serial bit delay with a saturating fill tracker.
// Define SISO_PARALLEL_TAP_EN to expose every stage on tap_out (bit 0 = newest).
module siso_shift_register
    import siso_pkg::*;
#(
    parameter int   DEPTH     = SISO_DEFAULT_DEPTH,
    parameter logic RESET_VAL = SISO_RESET_VAL,
    localparam int  CW        = siso_cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_in,
    output logic          data_out,
    output logic          out_valid,
`ifdef SISO_PARALLEL_TAP_EN
    output logic [DEPTH-1:0] tap_out,
`endif
    output logic [CW-1:0] fill_cnt
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [DEPTH-1:0] w_stage;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic w_d;
        if (g == 0) begin : g_head
            assign w_d = data_in;
        end else begin : g_body
            assign w_d = w_stage[g-1];
        end
        siso_stage #(.RESET_VAL(RESET_VAL)) u_stage (
            .clk   (clk),
            .rst_n (rst),
            .d     (w_d),
            .q     (w_stage[g])
        );
    end

    // valid is registered on the same edge the counter reaches FULL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (r_cnt != FULL) begin
            r_cnt   <= r_cnt + CW'(1);
            r_valid <= (r_cnt == LAST);
        end
    end

    assign data_out  = w_stage[DEPTH-1];
    assign fill_cnt  = r_cnt;
    assign out_valid = r_valid;

`ifdef SISO_PARALLEL_TAP_EN
    assign tap_out = w_stage;
`endif

endmodule

// File: tb/tb_siso_shift_register.sv
// Self-checking bench: DEPTH=4 and DEPTH=1 instances against a history-queue model.
module tb_siso_shift_register;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic       out4, vld4, out1, vld1;
    logic [2:0] fill4;
    logic [0:0] fill1;
`ifdef SISO_PARALLEL_TAP_EN
    logic [3:0] tap4;
    logic [0:0] tap1;
`endif

    int total = 0;
    int bad   = 0;

    // model: samples accepted since the last reset, newest at the back
    bit hist[$];
    int nshift = 0;

    siso_shift_register #(.DEPTH(4), .RESET_VAL(1'b0)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_out  (out4),
        .out_valid (vld4),
`ifdef SISO_PARALLEL_TAP_EN
        .tap_out   (tap4),
`endif
        .fill_cnt  (fill4)
    );

    siso_shift_register #(.DEPTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_out  (out1),
        .out_valid (vld1),
`ifdef SISO_PARALLEL_TAP_EN
        .tap_out   (tap1),
`endif
        .fill_cnt  (fill1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic bit exp_out(input int d);
        if (nshift >= d) return hist[hist.size() - d];
        return 1'b0;
    endfunction

    function automatic int exp_fill(input int d);
        return (nshift >= d) ? d : nshift;
    endfunction

    function automatic bit exp_vld(input int d);
        return nshift >= d;
    endfunction

    function automatic logic [3:0] exp_tap4();
        logic [3:0] t;
        t = '0;
        for (int i = 0; i < 4; i++)
            if (nshift > i) t[i] = hist[hist.size() - 1 - i];
        return t;
    endfunction

    task automatic model_clear();
        hist.delete();
        nshift = 0;
    endtask

    // drive one bit, take one edge, update the model, settle
    task automatic step(input bit b);
        data_in = b;
        @(posedge clk);
        if (rst) begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            nshift++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        step(1'b0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < 2; c++) begin
            step(1'b1);
            total++;
            if ({out4, vld4, fill4} !== 5'b0) begin
                bad++;
                $display("FAIL reset4 cyc%0d: got out=%b vld=%b fill=%0d want 0/0/0", c, out4, vld4, fill4);
            end
            total++;
            if ({out1, vld1, fill1} !== 3'b0) begin
                bad++;
                $display("FAIL reset1 cyc%0d: got out=%b vld=%b fill=%0d want 0/0/0", c, out1, vld1, fill1);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_single_pulse();
        int highs;
        do_reset();
        highs = 0;
        for (int e = 1; e <= 10; e++) begin
            step(e == 1);
            if (out4 === 1'b1) highs++;
            total++;
            if (out4 !== (e == 4)) begin
                bad++;
                $display("FAIL pulse edge%0d: got data_out=%b want %b", e, out4, (e == 4));
            end
        end
        total++;
        if (highs != 1) begin
            bad++;
            $display("FAIL pulse_width: got %0d high cycles want 1", highs);
        end
    endtask

    task automatic test_pattern();
        bit         pin  [7] = '{1, 0, 1, 1, 0, 0, 0};
        bit         dout [7] = '{0, 0, 0, 1, 0, 1, 1};
        logic [2:0] fill [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
        bit         d1   [7] = '{1, 0, 1, 1, 0, 0, 0};
        do_reset();
        for (int e = 0; e < 7; e++) begin
            step(pin[e]);
            total++;
            if ({out4, vld4, fill4} !== {dout[e], (e >= 3), fill[e]}) begin
                bad++;
                $display("FAIL pattern4 edge%0d: got out=%b vld=%b fill=%0d want %b/%b/%0d",
                         e + 1, out4, vld4, fill4, dout[e], (e >= 3), fill[e]);
            end
            total++;
            if ({out1, vld1, fill1} !== {d1[e], 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL pattern1 edge%0d: got out=%b vld=%b fill=%0d want %b/1/1",
                         e + 1, out1, vld1, fill1, d1[e]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1);
        step(1'b1);
        #2 rst = 1'b0;
        model_clear();
        #1;
        total++;
        if ({out4, vld4, fill4, out1, vld1, fill1} !== 8'b0) begin
            bad++;
            $display("FAIL async_clear: got out4=%b vld4=%b fill4=%0d out1=%b vld1=%b fill1=%0d want all 0",
                     out4, vld4, fill4, out1, vld1, fill1);
        end
        step(1'b1);
        rst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step(1'b1);
            total++;
            if ({out4, vld4, fill4} !== {exp_out(4), exp_vld(4), 3'(exp_fill(4))}) begin
                bad++;
                $display("FAIL refill edge%0d: got out=%b vld=%b fill=%0d want %b/%b/%0d",
                         e, out4, vld4, fill4, exp_out(4), exp_vld(4), exp_fill(4));
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(29) == 0) begin
                #2 rst = 1'b0;
                model_clear();
                #1;
                total++;
                if ({out4, vld4, fill4, out1, vld1, fill1} !== 8'b0) begin
                    bad++;
                    $display("FAIL rand_rst n%0d: outputs not cleared", n);
                end
                step(1'($urandom));
                rst = 1'b1;
            end
            step(1'($urandom));
            total++;
            if ({out4, vld4, fill4} !== {exp_out(4), exp_vld(4), 3'(exp_fill(4))}) begin
                bad++;
                $display("FAIL rand4 n%0d: got out=%b vld=%b fill=%0d want %b/%b/%0d",
                         n, out4, vld4, fill4, exp_out(4), exp_vld(4), exp_fill(4));
            end
            total++;
            if ({out1, vld1, fill1} !== {exp_out(1), exp_vld(1), 1'(exp_fill(1))}) begin
                bad++;
                $display("FAIL rand1 n%0d: got out=%b vld=%b fill=%0d want %b/%b/%0d",
                         n, out1, vld1, fill1, exp_out(1), exp_vld(1), exp_fill(1));
            end
`ifdef SISO_PARALLEL_TAP_EN
            total++;
            if (tap4 !== exp_tap4()) begin
                bad++;
                $display("FAIL rand_tap n%0d: got tap=%b want %b", n, tap4, exp_tap4());
            end
`endif
        end
    endtask

`ifdef SISO_PARALLEL_TAP_EN
    task automatic test_tap();
        bit pin [4] = '{1, 1, 0, 1};
        do_reset();
        for (int e = 0; e < 4; e++) step(pin[e]);
        total++;
        if (tap4 !== 4'b1011) begin
            bad++;
            $display("FAIL tap_pattern: got tap=%b want 1011", tap4);
        end
        #2 rst = 1'b0;
        model_clear();
        #1;
        total++;
        if (tap4 !== 4'b0000) begin
            bad++;
            $display("FAIL tap_reset: got tap=%b want 0000", tap4);
        end
        step(1'b0);
        rst = 1'b1;
    endtask
`endif

    initial begin
        rst     = 1'b0;
        data_in = 1'b0;
        #3;
        test_reset();
        test_single_pulse();
        test_pattern();
        test_async_reset();
`ifdef SISO_PARALLEL_TAP_EN
        test_tap();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
